// File: rtl/clint_arbiter.sv
//------------------------------------------------------------------------------
// Module      : clint_arbiter
// Description : Two-master round-robin arbiter in front of the single CLINT
//               register port. One access in flight at a time. A read of
//               mtime lo (word 0) also fetches mtime hi (word 1) into a
//               per-master shadow so the following word-1 read is tear-free.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module clint_arbiter #(
    parameter int SNAPSHOT = 1,
    parameter int NWORDS   = 5
) (
    input  logic        clk,
    input  logic        rst,
    // master 0: core data-side MMIO
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    // master 1: debug / DMA
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    // CLINT register port
    output logic        clint_en,
    output logic        clint_we,
    output logic [31:0] clint_addr,
    output logic [31:0] clint_wdata,
    input  logic [31:0] clint_rdata
);

    localparam logic [31:0] c_NWORDS = 32'(NWORDS);
    localparam logic        c_SNAP   = (SNAPSHOT != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACC    = 2'd1,
        S_ACC_HI = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_sel;          // master owning the current access
    logic        r_last;         // master granted last; tie goes to the other one
    logic        r_we;
    logic [2:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_snap;         // read of mtime lo with hi fetch into shadow
    logic        r_hit;          // read of mtime hi served from shadow
    logic [31:0] r_resp;         // captured lo word or shadow value
    logic [1:0]  r_shv;          // shadow valid, one bit per master
    logic [31:0] r_shadow0;
    logic [31:0] r_shadow1;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_err0;
    logic        r_err1;
    logic        r_clint_en;
    logic        r_clint_we;
    logic [31:0] r_clint_addr;
    logic [31:0] r_clint_wdata;

    logic        w_pick;
    logic        w_we;
    logic [2:0]  w_addr;
    logic [31:0] w_wdata;
    logic        w_bad;
    logic        w_snap;
    logic        w_hit;
    logic [31:0] w_resp_data;

    // Winner selection and request decode for the IDLE sample cycle
    always_comb begin
        w_pick  = (m0_req && m1_req) ? ~r_last : m1_req;
        w_we    = w_pick ? m1_we    : m0_we;
        w_addr  = w_pick ? m1_addr  : m0_addr;
        w_wdata = w_pick ? m1_wdata : m0_wdata;
        w_bad   = ({29'd0, w_addr} >= c_NWORDS);
        w_snap  = c_SNAP && !w_we && !w_bad && (w_addr == 3'd0);
        w_hit   = !w_we && !w_bad && (w_addr == 3'd1) && r_shv[w_pick];
    end

    // Response data source: zero for writes/errors, held register for
    // snapshot/shadow reads, otherwise the CLINT's registered read data
    always_comb begin
        w_resp_data = '0;
        if (!r_we && !r_err) begin
            w_resp_data = (r_snap || r_hit) ? r_resp : clint_rdata;
        end
    end

    // Arbitration FSM with registered CLINT-port and acknowledge outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sel         <= 1'b0;
            r_last        <= 1'b1;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_err         <= 1'b0;
            r_snap        <= 1'b0;
            r_hit         <= 1'b0;
            r_resp        <= '0;
            r_shv         <= 2'b00;
            r_shadow0     <= '0;
            r_shadow1     <= '0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_err0        <= 1'b0;
            r_err1        <= 1'b0;
            r_clint_en    <= 1'b0;
            r_clint_we    <= 1'b0;
            r_clint_addr  <= '0;
            r_clint_wdata <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        r_sel   <= w_pick;
                        r_we    <= w_we;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_err   <= w_bad;
                        r_snap  <= w_snap;
                        r_hit   <= w_hit;
                        if (w_hit) begin
                            // shadow hit: answer next cycle without touching the CLINT
                            r_resp  <= w_pick ? r_shadow1 : r_shadow0;
                            r_ack0  <= ~w_pick;
                            r_ack1  <= w_pick;
                            r_state <= S_RESP;
                        end else begin
                            r_clint_en    <= ~w_bad;
                            r_clint_we    <= ~w_bad & w_we;
                            r_clint_addr  <= w_bad ? 32'd0 : {29'd0, w_addr};
                            r_clint_wdata <= w_bad ? 32'd0 : w_wdata;
                            r_state       <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    // any write may change mtime, so no shadow can be trusted
                    if (r_we) begin
                        r_shv <= 2'b00;
                    end
                    if (r_snap) begin
                        r_clint_en    <= 1'b1;
                        r_clint_we    <= 1'b0;
                        r_clint_addr  <= 32'd1;
                        r_clint_wdata <= '0;
                        r_state       <= S_ACC_HI;
                    end else begin
                        r_clint_en    <= 1'b0;
                        r_clint_we    <= 1'b0;
                        r_clint_addr  <= '0;
                        r_clint_wdata <= '0;
                        r_ack0        <= ~r_sel;
                        r_ack1        <= r_sel;
                        r_err0        <= ~r_sel & r_err;
                        r_err1        <= r_sel & r_err;
                        r_state       <= S_RESP;
                    end
                end
                S_ACC_HI: begin
                    // clint_rdata now carries mtime lo from the ACC access
                    r_resp        <= clint_rdata;
                    r_clint_en    <= 1'b0;
                    r_clint_we    <= 1'b0;
                    r_clint_addr  <= '0;
                    r_clint_wdata <= '0;
                    r_ack0        <= ~r_sel;
                    r_ack1        <= r_sel;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    r_last <= r_sel;
                    if (r_snap) begin
                        // clint_rdata now carries mtime hi from the ACC_HI access
                        if (r_sel) begin
                            r_shadow1 <= clint_rdata;
                        end else begin
                            r_shadow0 <= clint_rdata;
                        end
                        r_shv[r_sel] <= 1'b1;
                    end
                    if (r_hit) begin
                        r_shv[r_sel] <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m0_ack      = r_ack0;
    assign m1_ack      = r_ack1;
    assign m0_err      = r_err0;
    assign m1_err      = r_err1;
    assign m0_rdata    = r_ack0 ? w_resp_data : 32'd0;
    assign m1_rdata    = r_ack1 ? w_resp_data : 32'd0;
    assign clint_en    = r_clint_en;
    assign clint_we    = r_clint_we;
    assign clint_addr  = r_clint_addr;
    assign clint_wdata = r_clint_wdata;

endmodule

`default_nettype wire
